// File: rtl/inst_sequencer.sv
// Instruction sequencer: plays a small program store onto a timed execute bus.
// Define SEQ_LOOP_EN to repeat the program until stop and expose loop_cnt.
module inst_sequencer #(
    parameter int DEPTH       = 16,
    parameter int EXEC_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [31:0]                prog_data,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic                       start,
    input  logic                       stop,
    output logic [31:0]                inst,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic                       busy,
`ifdef SEQ_LOOP_EN
    output logic [15:0]                loop_cnt,
`endif
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [AW:0]   LMAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L = (AW+1)'(1);
    localparam logic [CW-1:0] CLAST = CW'(EXEC_CYCLES - 1);
    localparam logic [31:0]   XBIT  = 32'h8000_0000;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t        state, state_d;
    logic [AW-1:0] pc_d;
    logic [CW-1:0] cyc_cnt, cnt_d;
    logic [AW:0]   len, len_d;
    logic          stop_pend, pend_d, pend_now, last;
    logic [31:0]   inst_d;
    logic [31:0]   mem [DEPTH];
`ifdef SEQ_LOOP_EN
    logic [15:0]   loop_d;
`endif

    // Program store: no reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && state == IDLE)
            mem[prog_addr] <= prog_data;
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        cnt_d    = cyc_cnt;
        len_d    = len;
        pend_d   = stop_pend;
        inst_d   = '0;
`ifdef SEQ_LOOP_EN
        loop_d   = loop_cnt;
`endif
        pend_now = stop_pend | stop;
        last     = ({1'b0, pc} == len - ONE_L);
        unique case (state)
            IDLE: begin
                pc_d  = '0;
                cnt_d = '0;
                if (start) begin
                    len_d  = (prog_len > LMAX) ? LMAX : prog_len;
                    pend_d = stop;
`ifdef SEQ_LOOP_EN
                    loop_d = '0;
`endif
                    if (len_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        inst_d  = mem[0] | XBIT;
                    end
                end
            end
            ISSUE: begin
                pend_d = pend_now;
                if (cyc_cnt == CLAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    inst_d  = mem[pc] & ~XBIT;
                end else begin
                    cnt_d  = cyc_cnt + CW'(1);
                    inst_d = mem[pc] | XBIT;
                end
            end
            GAP: begin
                pend_d = pend_now;
`ifdef SEQ_LOOP_EN
                if (last && loop_cnt != 16'hFFFF)
                    loop_d = loop_cnt + 16'd1;
`endif
                if (pend_now || (last && !LOOP)) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    pc_d    = last ? '0 : pc + AW'(1);
                    inst_d  = mem[pc_d] | XBIT;
                end
            end
            DONE: begin
                state_d = IDLE;
                pc_d    = '0;
                pend_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            cyc_cnt   <= '0;
            len       <= '0;
            stop_pend <= 1'b0;
            inst      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_LOOP_EN
            loop_cnt  <= '0;
`endif
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            cyc_cnt   <= cnt_d;
            len       <= len_d;
            stop_pend <= pend_d;
            inst      <= inst_d;
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
`ifdef SEQ_LOOP_EN
            loop_cnt  <= loop_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: vector table of runs plus
// hand-written reset, write-protect and loop sequences.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        stop;
    logic [31:0] inst;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
`ifdef SEQ_LOOP_EN
    logic [15:0] loop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog [16];

    typedef struct {
        int len;
        int stop_at;
        int exp_done;
        int exp_exec;
    } vec_t;

    vec_t vecs [$];

    inst_sequencer #(.DEPTH(16), .EXEC_CYCLES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .prog_len (prog_len),
        .start    (start),
        .stop     (stop),
        .inst     (inst),
        .pc       (pc),
        .busy     (busy),
`ifdef SEQ_LOOP_EN
        .loop_cnt (loop_cnt),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // stop_at: -1 never, 0 together with start, n during run cycle n
    task automatic run(input int len, input int stop_at,
                       input int exp_done, input int exp_exec);
        int n, exec, idx, lc;
        bit got;
        logic prev_x;
        lc       = (len > 16) ? 16 : len;
        prog_len = 5'(len);
        start    = 1'b1;
        stop     = (stop_at == 0);
        tick();
        start  = 1'b0;
        stop   = 1'b0;
        n      = 1;
        exec   = 0;
        idx    = 0;
        got    = 1'b0;
        prev_x = 1'b0;
        while (n <= 400 && !got) begin
            stop = (stop_at == n);
            if (n == 1)
                chk("first_exec", {31'd0, inst[31]}, {31'd0, lc != 0});
            if (done) begin
                got = 1'b1;
                chk("done_inst", inst, 32'h0);
                chk("done_busy", {31'd0, busy}, 32'd1);
            end else begin
                if (inst[31] && !prev_x) begin
                    chk("pc_seq", {28'd0, pc}, idx % lc);
                    idx++;
                end
                if (busy && (inst[30:0] != prog[pc][30:0]))
                    chk("inst_body", {1'b0, inst[30:0]},
                        {1'b0, prog[pc][30:0]});
                if (inst[31])
                    exec++;
            end
            prev_x = inst[31];
            if (!got) begin
                tick();
                n++;
            end
        end
        stop = 1'b0;
        chk("done_cycle", n, exp_done);
        chk("exec_cycles", exec, exp_exec);
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_pc", {28'd0, pc}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        start     = 1'b0;
        stop      = 1'b0;
        #2;
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;

        prog[0] = 32'h0000_0001;
        prog[1] = 32'h0000_0422;
        prog[2] = 32'h0000_0843;
        for (int i = 3; i < 16; i++)
            prog[i] = 32'hA5A5_0000 | 32'(i);
        for (int i = 0; i < 16; i++)
            wr(i, prog[i]);

`ifdef SEQ_LOOP_EN
        vecs.push_back('{2, 50, 55, 48});
        vecs.push_back('{0, -1, 1, 0});
        vecs.push_back('{4, 12, 19, 16});
        vecs.push_back('{5, 0, 10, 8});
        foreach (vecs[i]) begin
            run(vecs[i].len, vecs[i].stop_at,
                vecs[i].exp_done, vecs[i].exp_exec);
            if (i == 0)
                chk("loop_cnt_3", {16'd0, loop_cnt}, 32'd3);
        end
        chk("loop_cnt_clr", {16'd0, loop_cnt}, 32'd0);
`else
        vecs.push_back('{3, -1, 28, 24});
        vecs.push_back('{0, -1, 1, 0});
        vecs.push_back('{1, -1, 10, 8});
        vecs.push_back('{20, -1, 145, 128});
        vecs.push_back('{16, -1, 145, 128});
        vecs.push_back('{4, 12, 19, 16});
        vecs.push_back('{5, 0, 10, 8});
        foreach (vecs[i])
            run(vecs[i].len, vecs[i].stop_at,
                vecs[i].exp_done, vecs[i].exp_exec);

        // Store write and second start while busy must both be ignored.
        prog_len = 5'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 32'hFFFF_FFFF;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        n = 4;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("busy_start_ign", n, 10);
        tick();
        chk("busy_start_idle", {31'd0, busy}, 32'd0);
        run(1, -1, 10, 8);
`endif

        // Asynchronous reset in the 4th ISSUE cycle.
        prog_len = 5'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_exec", {31'd0, inst[31]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_inst", inst, 32'h0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_pc", {28'd0, pc}, 32'd0);
        tick();
        chk("arst_hold_done", {31'd0, done}, 32'd0);
        #2 rst_n = 1'b1;
        run(3, -1, 28, 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
